id_stage_fwd: RTL

Parametrised decode stage for the armcpu MIPS pipeline. It sits between the IF and EX stages and replaces the fixed, stall-only decoder with a valid/ready handshake, flush support, operand forwarding from EX/MEM/WB, load-use interlock and invalid-instruction flagging. It owns the architectural register file and drives the registered ID→EX fields.

---
 rtl/id_stage_fwd_pkg.sv | 54 +++++
 rtl/id_stage_fwd_regfile.sv | 42 ++++
 rtl/id_stage_fwd.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_fwd_pkg.sv
// Shared decode constants for the armcpu ID stage: ALU/memory/branch operation codes,
// MIPS opcode and func values, and the interlock FSM state encoding.
package id_stage_fwd_pkg;

  // ALU operations. R-type ops carry func in the low 6 bits; bit 6 marks internal ops.
  localparam int unsigned ALU_OPT_WIDTH = 7;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_DISABLE   = 7'h40;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_PASS_OPR1 = 7'h41;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_ADDU      = 7'h21;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_SUBU      = 7'h23;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_AND       = 7'h24;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_OR        = 7'h25;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_XOR       = 7'h26;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_SLT       = 7'h2a;

  localparam int unsigned MEM_OPT_WIDTH = 2;
  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_NONE = 2'd0;
  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LW   = 2'd1;
  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_SW   = 2'd2;

  localparam int unsigned BRANCH_OPT_WIDTH = 3;
  localparam logic [BRANCH_OPT_WIDTH-1:0] BRANCH_NONE       = 3'd0;
  localparam logic [BRANCH_OPT_WIDTH-1:0] BRANCH_ON_ALU_EQZ = 3'd1;
  localparam logic [BRANCH_OPT_WIDTH-1:0] BRANCH_ON_ALU_NEZ = 3'd2;
  localparam logic [BRANCH_OPT_WIDTH-1:0] BRANCH_UNCOND     = 3'd3;
  localparam logic [BRANCH_OPT_WIDTH-1:0] BRANCH_ON_REG     = 3'd4;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FUNC_JR   = 6'h08;
  localparam logic [5:0] FUNC_JALR = 6'h09;

  typedef enum logic [0:0] {
    StRun       = 1'b0,
    StInterlock = 1'b1
  } id_state_e;

  function automatic logic [ALU_OPT_WIDTH-1:0] alu_opt_from_func(input logic [5:0] func);
    return {1'b0, func};
  endfunction

endpackage

// File: rtl/id_stage_fwd_regfile.sv
// Architectural register file: two asynchronous read ports, one write port applied at the
// clock edge. Register 0 is never written and always reads as zero.
// Ports: clk, rst (sync, active-high), waddr_i/wdata_i (addr 0 = no write),
// raddr1_i/rdata1_o, raddr2_i/rdata2_o.
module regfile_param #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic [RADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0]  rdata1_o,
  input  logic [RADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0]  rdata2_o
);

  localparam int unsigned NumRegs = 2 ** RADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];

  always_comb begin
    regs_d = regs_q;
    if (waddr_i != '0) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/id_stage_fwd.sv
// MIPS decode stage with valid/ready handshake, flush, EX/MEM/WB operand forwarding,
// load-use interlock and invalid-opcode flagging. Owns the register file and registers
// all ID->EX fields.
// Ports: clk, rst (sync, active-high), flush; IF side in_valid/in_ready/in_pc/in_instr;
// EX side ex_ready, out_* fields; register write port wb_addr/wb_data; forwarding
// sources fwd_ex_* and fwd_mem_*.
module id_stage_fwd
  import id_stage_fwd_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned FWD_EN  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_pc,
  input  logic [31:0]                 in_instr,
  input  logic                        ex_ready,
  input  logic [RADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]           wb_data,
  input  logic [RADDR_W-1:0]          fwd_ex_addr,
  input  logic [DATA_W-1:0]           fwd_ex_data,
  input  logic                        fwd_ex_is_load,
  input  logic [RADDR_W-1:0]          fwd_mem_addr,
  input  logic [DATA_W-1:0]           fwd_mem_data,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_pc,
  output logic [RADDR_W-1:0]          reg1_addr,
  output logic [DATA_W-1:0]           reg1_data,
  output logic [RADDR_W-1:0]          reg2_addr,
  output logic [DATA_W-1:0]           reg2_data,
  output logic                        alu_src,
  output logic [ALU_OPT_WIDTH-1:0]    alu_opt,
  output logic [DATA_W-1:0]           alu_sa_imm,
  output logic [RADDR_W-1:0]          wb_reg_addr,
  output logic [MEM_OPT_WIDTH-1:0]    mem_opt,
  output logic [BRANCH_OPT_WIDTH-1:0] branch_opt,
  output logic [DATA_W-1:0]           branch_dest,
  output logic                        exc_invalid
);

  // Instruction fields
  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;
  assign opcode = in_instr[31:26];
  assign rs     = in_instr[25:21];
  assign rt     = in_instr[20:16];
  assign rd     = in_instr[15:11];
  assign sa     = in_instr[10:6];
  assign func   = in_instr[5:0];
  assign imm    = in_instr[15:0];

  logic [DATA_W-1:0] simm, zimm, pc_rel, pc_region, link_val;
  assign simm      = {{(DATA_W-16){imm[15]}}, imm};
  assign zimm      = {{(DATA_W-16){1'b0}}, imm};
  assign pc_rel    = in_pc + {simm[DATA_W-3:0], 2'b00};
  assign pc_region = {in_pc[DATA_W-1:28], in_instr[25:0], 2'b00};
  assign link_val  = in_pc + DATA_W'(4);

  // Decoded fields
  logic [RADDR_W-1:0]          dec_reg1_addr, dec_reg2_addr, dec_wb_addr;
  logic                        dec_alu_src, dec_link, dec_invalid;
  logic [ALU_OPT_WIDTH-1:0]    dec_alu_opt;
  logic [DATA_W-1:0]           dec_imm, dec_dest;
  logic [MEM_OPT_WIDTH-1:0]    dec_mem_opt;
  logic [BRANCH_OPT_WIDTH-1:0] dec_branch_opt;

  always_comb begin
    dec_reg1_addr  = '0;
    dec_reg2_addr  = '0;
    dec_wb_addr    = '0;
    dec_alu_src    = 1'b0;
    dec_alu_opt    = ALU_OPT_DISABLE;
    dec_imm        = '0;
    dec_mem_opt    = MEM_OPT_NONE;
    dec_branch_opt = BRANCH_NONE;
    dec_dest       = '0;
    dec_link       = 1'b0;
    dec_invalid    = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        if (func == FUNC_JR) begin
          dec_reg2_addr  = RADDR_W'(rs);
          dec_branch_opt = BRANCH_ON_REG;
        end else if (func == FUNC_JALR) begin
          dec_reg2_addr  = RADDR_W'(rs);
          dec_branch_opt = BRANCH_ON_REG;
          dec_link       = 1'b1;
          dec_alu_opt    = ALU_OPT_PASS_OPR1;
          dec_wb_addr    = RADDR_W'(rd);
        end else begin
          dec_reg1_addr = RADDR_W'(rs);
          dec_reg2_addr = RADDR_W'(rt);
          dec_wb_addr   = RADDR_W'(rd);
          dec_alu_opt   = alu_opt_from_func(func);
          dec_imm       = {{(DATA_W-5){1'b0}}, sa};
        end
      end
      OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
        dec_reg1_addr = RADDR_W'(rs);
        dec_wb_addr   = RADDR_W'(rt);
        dec_alu_src   = 1'b1;
        dec_imm       = simm;
        case (opcode)
          OP_SLTI: dec_alu_opt = ALU_OPT_SLT;
          OP_ANDI: begin dec_alu_opt = ALU_OPT_AND; dec_imm = zimm; end
          OP_ORI:  begin dec_alu_opt = ALU_OPT_OR;  dec_imm = zimm; end
          OP_XORI: begin dec_alu_opt = ALU_OPT_XOR; dec_imm = zimm; end
          OP_LW:   begin dec_alu_opt = ALU_OPT_ADDU; dec_mem_opt = MEM_OPT_LW; end
          default: dec_alu_opt = ALU_OPT_ADDU;
        endcase
      end
      // LUI is r0 | (imm << 16), so it needs no dedicated ALU op.
      OP_LUI: begin
        dec_wb_addr = RADDR_W'(rt);
        dec_alu_src = 1'b1;
        dec_alu_opt = ALU_OPT_OR;
        dec_imm     = zimm << 16;
      end
      OP_SW: begin
        dec_reg1_addr = RADDR_W'(rs);
        dec_reg2_addr = RADDR_W'(rt);
        dec_alu_src   = 1'b1;
        dec_alu_opt   = ALU_OPT_ADDU;
        dec_imm       = simm;
        dec_mem_opt   = MEM_OPT_SW;
      end
      OP_BEQ, OP_BNE: begin
        dec_reg1_addr  = RADDR_W'(rs);
        dec_reg2_addr  = RADDR_W'(rt);
        dec_alu_opt    = ALU_OPT_SUBU;
        dec_dest       = pc_rel;
        dec_branch_opt = (opcode == OP_BEQ) ? BRANCH_ON_ALU_EQZ : BRANCH_ON_ALU_NEZ;
      end
      OP_J, OP_JAL: begin
        dec_dest       = pc_region;
        dec_branch_opt = BRANCH_UNCOND;
        if (opcode == OP_JAL) begin
          dec_link    = 1'b1;
          dec_alu_opt = ALU_OPT_PASS_OPR1;
          dec_wb_addr = RADDR_W'(31);
        end
      end
      default: dec_invalid = 1'b1;
    endcase
  end

  // Register file and operand selection
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2, op1, op2;

  regfile_param #(
    .DATA_W (DATA_W),
    .RADDR_W(RADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .waddr_i (wb_addr),
    .wdata_i (wb_data),
    .raddr1_i(dec_reg1_addr),
    .rdata1_o(rf_rdata1),
    .raddr2_i(dec_reg2_addr),
    .rdata2_o(rf_rdata2)
  );

  function automatic logic [DATA_W-1:0] pick_operand(input logic [RADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0]  rf_val);
    logic [DATA_W-1:0] val;
    val = rf_val;
    if (addr == '0) begin
      val = '0;
    end else if ((FWD_EN != 0) && (fwd_ex_addr == addr)) begin
      val = fwd_ex_data;
    end else if ((FWD_EN != 0) && (fwd_mem_addr == addr)) begin
      val = fwd_mem_data;
    end else if (wb_addr == addr) begin
      val = wb_data;
    end
    return val;
  endfunction

  assign op1 = dec_link ? link_val : pick_operand(dec_reg1_addr, rf_rdata1);
  assign op2 = pick_operand(dec_reg2_addr, rf_rdata2);

  // Hazard detection
  logic ex_hit, mem_hit, hazard;
  assign ex_hit  = (fwd_ex_addr != '0) &&
                   ((fwd_ex_addr == dec_reg1_addr) || (fwd_ex_addr == dec_reg2_addr));
  assign mem_hit = (fwd_mem_addr != '0) &&
                   ((fwd_mem_addr == dec_reg1_addr) || (fwd_mem_addr == dec_reg2_addr));
  // Without bypass muxes any in-flight writer of a source must drain first.
  assign hazard  = in_valid & ((ex_hit & fwd_ex_is_load) | ((FWD_EN == 0) & (ex_hit | mem_hit)));

  // Output registers
  id_state_e                   state_q, state_d;
  logic                        out_valid_q, out_valid_d;
  logic [DATA_W-1:0]           out_pc_q, out_pc_d;
  logic [RADDR_W-1:0]          reg1_addr_q, reg1_addr_d, reg2_addr_q, reg2_addr_d;
  logic [DATA_W-1:0]           reg1_data_q, reg1_data_d, reg2_data_q, reg2_data_d;
  logic                        alu_src_q, alu_src_d;
  logic [ALU_OPT_WIDTH-1:0]    alu_opt_q, alu_opt_d;
  logic [DATA_W-1:0]           alu_sa_imm_q, alu_sa_imm_d;
  logic [RADDR_W-1:0]          wb_reg_addr_q, wb_reg_addr_d;
  logic [MEM_OPT_WIDTH-1:0]    mem_opt_q, mem_opt_d;
  logic [BRANCH_OPT_WIDTH-1:0] branch_opt_q, branch_opt_d;
  logic [DATA_W-1:0]           branch_dest_q, branch_dest_d;
  logic                        exc_invalid_q, exc_invalid_d;

  logic advance, accept;
  assign advance  = ~out_valid_q | ex_ready;
  assign in_ready = advance & ~hazard & ~flush & ~rst;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StRun;
    end else if (hazard) begin
      state_d = StInterlock;
    end else if (state_q == StInterlock) begin
      state_d = StRun;
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    reg1_addr_d   = reg1_addr_q;
    reg1_data_d   = reg1_data_q;
    reg2_addr_d   = reg2_addr_q;
    reg2_data_d   = reg2_data_q;
    alu_src_d     = alu_src_q;
    alu_opt_d     = alu_opt_q;
    alu_sa_imm_d  = alu_sa_imm_q;
    wb_reg_addr_d = wb_reg_addr_q;
    mem_opt_d     = mem_opt_q;
    branch_opt_d  = branch_opt_q;
    branch_dest_d = branch_dest_q;
    exc_invalid_d = exc_invalid_q;
    // Held fields change only when EX takes them or a flush squashes them.
    if (flush || advance) begin
      out_valid_d   = accept;
      out_pc_d      = '0;
      reg1_addr_d   = '0;
      reg1_data_d   = '0;
      reg2_addr_d   = '0;
      reg2_data_d   = '0;
      alu_src_d     = 1'b0;
      alu_opt_d     = ALU_OPT_DISABLE;
      alu_sa_imm_d  = '0;
      wb_reg_addr_d = '0;
      mem_opt_d     = MEM_OPT_NONE;
      branch_opt_d  = BRANCH_NONE;
      branch_dest_d = '0;
      exc_invalid_d = 1'b0;
      if (accept) begin
        out_pc_d      = in_pc;
        reg1_addr_d   = dec_reg1_addr;
        reg1_data_d   = op1;
        reg2_addr_d   = dec_reg2_addr;
        reg2_data_d   = op2;
        alu_src_d     = dec_alu_src;
        alu_opt_d     = dec_alu_opt;
        alu_sa_imm_d  = dec_imm;
        wb_reg_addr_d = dec_wb_addr;
        mem_opt_d     = dec_mem_opt;
        branch_opt_d  = dec_branch_opt;
        branch_dest_d = dec_dest;
        exc_invalid_d = dec_invalid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      reg1_addr_q   <= '0;
      reg1_data_q   <= '0;
      reg2_addr_q   <= '0;
      reg2_data_q   <= '0;
      alu_src_q     <= 1'b0;
      alu_opt_q     <= ALU_OPT_DISABLE;
      alu_sa_imm_q  <= '0;
      wb_reg_addr_q <= '0;
      mem_opt_q     <= MEM_OPT_NONE;
      branch_opt_q  <= BRANCH_NONE;
      branch_dest_q <= '0;
      exc_invalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      reg1_addr_q   <= reg1_addr_d;
      reg1_data_q   <= reg1_data_d;
      reg2_addr_q   <= reg2_addr_d;
      reg2_data_q   <= reg2_data_d;
      alu_src_q     <= alu_src_d;
      alu_opt_q     <= alu_opt_d;
      alu_sa_imm_q  <= alu_sa_imm_d;
      wb_reg_addr_q <= wb_reg_addr_d;
      mem_opt_q     <= mem_opt_d;
      branch_opt_q  <= branch_opt_d;
      branch_dest_q <= branch_dest_d;
      exc_invalid_q <= exc_invalid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign reg1_addr   = reg1_addr_q;
  assign reg1_data   = reg1_data_q;
  assign reg2_addr   = reg2_addr_q;
  assign reg2_data   = reg2_data_q;
  assign alu_src     = alu_src_q;
  assign alu_opt     = alu_opt_q;
  assign alu_sa_imm  = alu_sa_imm_q;
  assign wb_reg_addr = wb_reg_addr_q;
  assign mem_opt     = mem_opt_q;
  assign branch_opt  = branch_opt_q;
  assign branch_dest = branch_dest_q;
  assign exc_invalid = exc_invalid_q;

endmodule
